// File: rtl/moller_init_pkg.sv
// Shared types and constants for the moller bring-up master.
// Register offsets are relative to the register map base.
package moller_init_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_REV,
        WR_DLY,
        WR_CTRL_TP,
        POLL,
        RD_TD,
        WR_CTRL_RUN,
        DONE_S,
        ERR
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_REV     = 3'd1;
    localparam logic [2:0] ERR_RESP    = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_PATTERN = 3'd4;

    localparam logic [1:0] OKAY = 2'b00;

    localparam logic [31:0] REG_TEST_DATA = 32'h00;
    localparam logic [31:0] REG_REVISION  = 32'h40;
    localparam logic [31:0] REG_ADC_CTRL  = 32'h48;
    localparam logic [31:0] REG_STATUS    = 32'h5C;
    localparam logic [31:0] REG_DELAY     = 32'h60;

    localparam int STATUS_TRAINED_BIT = 2;
    localparam int CTRL_ENA_BIT       = 31;
    localparam int CTRL_TP_BIT        = 30;
    localparam int CTRL_PD_BIT        = 29;
    localparam int CTRL_RATE_LSB      = 16;
    localparam int CTRL_CHDIS_LSB     = 0;

    function automatic logic [31:0] ctrl_word(logic tp, logic [7:0] rate);
        logic [31:0] w;
        w = '0;
        w[CTRL_ENA_BIT] = 1'b1;
        w[CTRL_TP_BIT] = tp;
        w[CTRL_PD_BIT] = 1'b0;
        w[CTRL_RATE_LSB +: 8] = rate;
        w[CTRL_CHDIS_LSB +: 16] = 16'h0;
        return w;
    endfunction

endpackage

// File: rtl/moller_axil_xfer.sv
// Single-transaction AXI4-Lite master engine: one request in,
// one ack pulse out once the response channel has completed.
module moller_axil_xfer
    import moller_init_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        resp_err,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    logic active;
    logic is_wr;
    logic aw_done;
    logic w_done;
    logic aw_ok;
    logic w_ok;

    assign m_axi_wstrb = 4'hF;
    assign aw_ok = aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_ok  = w_done | (m_axi_wvalid & m_axi_wready);

    always_ff @(posedge clk) begin
        if (rst) begin
            active        <= 1'b0;
            is_wr         <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            ack           <= 1'b0;
            rdata         <= '0;
            resp_err      <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (req && !active) begin
                active  <= 1'b1;
                is_wr   <= wr;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (wr) begin
                    m_axi_awaddr  <= addr;
                    m_axi_wdata   <= wdata;
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                end else begin
                    m_axi_araddr  <= addr;
                    m_axi_arvalid <= 1'b1;
                end
            end
            if (m_axi_awvalid && m_axi_awready) begin
                m_axi_awvalid <= 1'b0;
                aw_done       <= 1'b1;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                m_axi_wvalid <= 1'b0;
                w_done       <= 1'b1;
            end
            // B is only accepted after both address and data have gone out
            if (active && is_wr && !m_axi_bready && aw_ok && w_ok)
                m_axi_bready <= 1'b1;
            if (m_axi_bready && m_axi_bvalid) begin
                m_axi_bready <= 1'b0;
                ack          <= 1'b1;
                resp_err     <= (m_axi_bresp != OKAY);
                active       <= 1'b0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b1;
            end
            if (m_axi_rready && m_axi_rvalid) begin
                m_axi_rready <= 1'b0;
                ack          <= 1'b1;
                rdata        <= m_axi_rdata;
                resp_err     <= (m_axi_rresp != OKAY);
                active       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/moller_axil_init_master.sv
// Bring-up sequencer for the moller register map: revision check,
// ADC delay load, training in test-pattern mode, audit, normal mode.
module moller_axil_init_master
    import moller_init_pkg::*;
#(
    parameter logic [31:0] BASEADDR          = 32'h8001_0000,
    parameter int          EXPECTED_REVISION = 249,
    parameter logic [8:0]  DELAY_INIT        = 9'd0,
    parameter logic [7:0]  SAMPLE_RATE       = 8'd0,
    parameter int          POLL_MAX          = 1024
) (
    input  logic        axi_aclk,
    input  logic        axi_reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  error_code,
    output logic [15:0] bad_ch_mask,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t        state;
    logic [3:0]    idx;
    logic [PW-1:0] poll_cnt;
    logic          pend;
    logic          req;
    logic          req_wr;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          ack;
    logic [31:0]   rdata;
    logic          resp_err;
    logic          nxt_wr;
    logic [31:0]   nxt_off;
    logic [31:0]   nxt_wdata;
    logic [31:0]   idx_off;

    assign idx_off = {26'b0, idx, 2'b00};

    always_comb begin
        nxt_wr    = 1'b0;
        nxt_off   = '0;
        nxt_wdata = '0;
        unique case (state)
            RD_REV: nxt_off = REG_REVISION;
            WR_DLY: begin
                nxt_wr    = 1'b1;
                nxt_off   = REG_DELAY + idx_off;
                nxt_wdata = {23'b0, DELAY_INIT};
            end
            WR_CTRL_TP: begin
                nxt_wr    = 1'b1;
                nxt_off   = REG_ADC_CTRL;
                nxt_wdata = ctrl_word(1'b1, SAMPLE_RATE);
            end
            POLL:  nxt_off = REG_STATUS;
            RD_TD: nxt_off = REG_TEST_DATA + idx_off;
            WR_CTRL_RUN: begin
                nxt_wr    = 1'b1;
                nxt_off   = REG_ADC_CTRL;
                nxt_wdata = ctrl_word(1'b0, SAMPLE_RATE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state       <= IDLE;
            idx         <= '0;
            poll_cnt    <= '0;
            pend        <= 1'b0;
            req         <= 1'b0;
            req_wr      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            error_code  <= ERR_NONE;
            bad_ch_mask <= '0;
        end else begin
            req <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        error_code  <= ERR_NONE;
                        bad_ch_mask <= '0;
                        idx         <= '0;
                        pend        <= 1'b0;
                        state       <= RD_REV;
                    end
                end
                DONE_S: begin
                    busy <= 1'b0;
                    if (|bad_ch_mask) begin
                        error      <= 1'b1;
                        error_code <= ERR_PATTERN;
                    end else begin
                        done <= 1'b1;
                    end
                    state <= IDLE;
                end
                ERR: begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    if (!pend) begin
                        req       <= 1'b1;
                        pend      <= 1'b1;
                        req_wr    <= nxt_wr;
                        req_addr  <= BASEADDR + nxt_off;
                        req_wdata <= nxt_wdata;
                    end else if (ack) begin
                        pend <= 1'b0;
                        if (resp_err) begin
                            error_code <= ERR_RESP;
                            state      <= ERR;
                        end else begin
                            unique case (state)
                                RD_REV: begin
                                    if (rdata != 32'(EXPECTED_REVISION)) begin
                                        error_code <= ERR_REV;
                                        state      <= ERR;
                                    end else begin
                                        idx   <= '0;
                                        state <= WR_DLY;
                                    end
                                end
                                WR_DLY: begin
                                    idx <= idx + 4'd1;
                                    if (idx == 4'd15)
                                        state <= WR_CTRL_TP;
                                end
                                WR_CTRL_TP: begin
                                    poll_cnt <= '0;
                                    state    <= POLL;
                                end
                                POLL: begin
                                    if (rdata[STATUS_TRAINED_BIT]) begin
                                        idx   <= '0;
                                        state <= RD_TD;
                                    end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                                        error_code <= ERR_TIMEOUT;
                                        state      <= ERR;
                                    end else begin
                                        poll_cnt <= poll_cnt + 1'b1;
                                    end
                                end
                                RD_TD: begin
                                    bad_ch_mask[idx] <= (rdata != '0);
                                    idx <= idx + 4'd1;
                                    if (idx == 4'd15)
                                        state <= WR_CTRL_RUN;
                                end
                                WR_CTRL_RUN: state <= DONE_S;
                                default: state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    moller_axil_xfer u_xfer (
        .clk           (axi_aclk),
        .rst           (axi_reset),
        .req           (req),
        .wr            (req_wr),
        .addr          (req_addr),
        .wdata         (req_wdata),
        .ack           (ack),
        .rdata         (rdata),
        .resp_err      (resp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

endmodule

// File: tb/tb_moller_axil_init_master.sv
// Bench for moller_axil_init_master: randomized AXI4-Lite slave plus
// a transaction-list model of the bring-up sequence.
module tb_moller_axil_init_master;

    localparam logic [31:0] BASE = 32'h8001_0000;
    localparam int PMAX = 8;

    logic        axi_aclk = 1'b0;
    logic        axi_reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  error_code;
    logic [15:0] bad_ch_mask;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] cfg_rev;
    int          cfg_poll_at;
    logic [31:0] cfg_td [16];
    logic [31:0] cfg_err;
    bit          stall;
    int          status_n;

    logic [64:0] log_q [$];
    logic [64:0] exp_q [$];

    always #5 axi_aclk = ~axi_aclk;

    moller_axil_init_master #(
        .POLL_MAX (PMAX)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .error_code    (error_code),
        .bad_ch_mask   (bad_ch_mask),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #2;
    endtask

    // Slave register map as seen by the master
    function automatic logic [31:0] slave_read(logic [31:0] a);
        logic [31:0] o;
        logic [31:0] r;
        o = a - BASE;
        r = 32'h0;
        if (o == 32'h40) begin
            r = cfg_rev;
        end else if (o == 32'h5C) begin
            status_n++;
            r = $urandom & ~32'h4;
            if (cfg_poll_at != 0 && status_n >= cfg_poll_at)
                r = r | 32'h4;
        end else if (o < 32'h40) begin
            r = cfg_td[o[5:2]];
        end
        return r;
    endfunction

    function automatic bit push(bit wr, logic [31:0] a, logic [31:0] d);
        exp_q.push_back({wr, a, d});
        return a == cfg_err;
    endfunction

    // Expected access list and outcome, straight from the sequence rules
    task automatic model(output logic [2:0] code, output logic [15:0] mask);
        int n;
        code = 3'd0;
        mask = 16'h0;
        exp_q.delete();
        if (push(1'b0, BASE + 32'h40, 32'h0)) begin code = 3'd2; return; end
        if (cfg_rev != 32'd249) begin code = 3'd1; return; end
        for (int i = 0; i < 16; i++)
            if (push(1'b1, BASE + 32'h60 + 4 * i, 32'h0)) begin
                code = 3'd2;
                return;
            end
        if (push(1'b1, BASE + 32'h48, 32'hC000_0000)) begin code = 3'd2; return; end
        n = (cfg_poll_at == 0 || cfg_poll_at > PMAX) ? PMAX : cfg_poll_at;
        for (int i = 0; i < n; i++)
            if (push(1'b0, BASE + 32'h5C, 32'h0)) begin code = 3'd2; return; end
        if (n != cfg_poll_at) begin code = 3'd3; return; end
        for (int i = 0; i < 16; i++) begin
            if (push(1'b0, BASE + 4 * i, 32'h0)) begin code = 3'd2; return; end
            mask[i] = (cfg_td[i] != 0);
        end
        if (push(1'b1, BASE + 32'h48, 32'h8000_0000)) begin code = 3'd2; return; end
        code = (mask != 0) ? 3'd4 : 3'd0;
    endtask

    // Slave: observes handshakes from the previous edge, drives at negedge
    logic        p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    initial begin : slave
        bit          got_aw, got_w, b_pend, r_pend, wr_out, rd_out;
        logic [31:0] aw_a, w_d, r_d;
        logic [1:0]  b_r, r_r;
        int          b_dly, r_dly;
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        wr_out = 0; rd_out = 0; b_dly = 0; r_dly = 0;
        aw_a = 0; w_d = 0; r_d = 0; b_r = 0; r_r = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0;
        forever begin
            @(negedge axi_aclk);
            if (axi_reset) begin
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
                wr_out = 0; rd_out = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_bresp = 0;
                m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
            end else begin
                if (p_awv && !m_axi_awready)
                    chk("aw_hold", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
                if (p_wv && !m_axi_wready)
                    chk("w_hold", {m_axi_wvalid, m_axi_wdata}, {1'b1, p_wdata});
                if (p_arv && !m_axi_arready)
                    chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
                if (p_awv && m_axi_awready) begin got_aw = 1; aw_a = p_awaddr; end
                if (p_wv && m_axi_wready) begin got_w = 1; w_d = p_wdata; end
                if (m_axi_bvalid && p_bready) begin m_axi_bvalid = 0; wr_out = 0; end
                if (m_axi_rvalid && p_rready) begin m_axi_rvalid = 0; rd_out = 0; end
                if (got_aw && got_w) begin
                    log_q.push_back({1'b1, aw_a, w_d});
                    b_r = (aw_a == cfg_err) ? 2'b10 : 2'b00;
                    b_pend = 1; wr_out = 1; got_aw = 0; got_w = 0;
                    b_dly = stall ? $urandom_range(0, 5) : 0;
                end
                if (p_arv && m_axi_arready) begin
                    log_q.push_back({1'b0, p_araddr, 32'h0});
                    r_d = slave_read(p_araddr);
                    r_r = (p_araddr == cfg_err) ? 2'b10 : 2'b00;
                    r_pend = 1; rd_out = 1;
                    r_dly = stall ? $urandom_range(0, 5) : 0;
                end
                if (b_pend) begin
                    if (b_dly == 0) begin
                        m_axi_bvalid = 1; m_axi_bresp = b_r; b_pend = 0;
                    end else b_dly--;
                end
                if (r_pend) begin
                    if (r_dly == 0) begin
                        m_axi_rvalid = 1; m_axi_rresp = r_r; m_axi_rdata = r_d;
                        r_pend = 0;
                    end else r_dly--;
                end
                if (m_axi_bready && !p_bready) chk("b_order", wr_out, 1'b1);
                if (m_axi_rready && !p_rready) chk("r_order", rd_out, 1'b1);
                m_axi_awready = !stall || ($urandom_range(0, 2) == 0);
                m_axi_wready  = !stall || ($urandom_range(0, 2) == 0);
                m_axi_arready = !stall || ($urandom_range(0, 2) == 0);
                p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
                p_wv = m_axi_wvalid; p_wdata = m_axi_wdata;
                p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
                p_bready = m_axi_bready; p_rready = m_axi_rready;
            end
        end
    end

    task automatic cfg_nominal();
        cfg_rev = 32'd249;
        cfg_poll_at = 3;
        cfg_err = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) cfg_td[i] = 32'h0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ctl"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             m_axi_arvalid, m_axi_rready, busy, done, error,
             error_code, bad_ch_mask}, 24'h0);
        chk({tag, "_addr"}, {m_axi_awaddr, m_axi_wdata, m_axi_araddr}, 96'h0);
    endtask

    task automatic run_case(input string name);
        logic [2:0]  ecode;
        logic [15:0] emask;
        int          n;
        model(ecode, emask);
        log_q.delete();
        status_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, "_busy"}, busy, 1'b1);
        n = 0;
        while (!(done || error) && n < 20000) begin
            tick();
            n++;
        end
        chk({name, "_finish"}, done || error, 1'b1);
        repeat (8) tick();
        chk({name, "_idle"}, busy, 1'b0);
        chk({name, "_done"}, done, ecode == 3'd0);
        chk({name, "_error"}, error, ecode != 3'd0);
        chk({name, "_code"}, error_code, ecode);
        chk({name, "_mask"}, bad_ch_mask, emask);
        chk({name, "_nxact"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_xact%0d", name, i), log_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        axi_reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        status_n = 0;
        cfg_nominal();
        repeat (3) tick();
        check_reset_state("reset");
        chk("wstrb", m_axi_wstrb, 4'hF);
        axi_reset = 1'b0;
        tick();

        cfg_nominal();
        run_case("nominal");

        cfg_nominal();
        cfg_rev = 32'd248;
        run_case("rev");

        cfg_nominal();
        cfg_poll_at = 0;
        run_case("timeout");

        cfg_nominal();
        cfg_td[5] = 32'h0003_0000;
        run_case("badtp");

        cfg_nominal();
        cfg_err = 32'h8001_0078;
        run_case("slverr");

        stall = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cfg_nominal();
            if ($urandom_range(0, 5) == 0) cfg_rev = 32'd249 ^ $urandom_range(1, 255);
            cfg_poll_at = $urandom_range(0, 10);
            for (int i = 0; i < 16; i++)
                cfg_td[i] = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1) : 32'h0;
            if ($urandom_range(0, 3) == 0)
                cfg_err = BASE + ($urandom_range(0, 1) ? 32'h60 : 32'h0)
                          + 4 * $urandom_range(0, 15);
            run_case($sformatf("rand%0d", k));
        end

        cfg_nominal();
        log_q.delete();
        status_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (log_q.size() < 5 && n < 2000) begin
            tick();
            n++;
        end
        chk("rst_reach_dly", log_q.size() >= 5, 1'b1);
        axi_reset = 1'b1;
        tick();
        check_reset_state("midrst");
        axi_reset = 1'b0;
        repeat (2) tick();
        run_case("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
